// File: rtl/hacd_pkg.sv
// hacd_pkg: shared ATT status codes, entry layout and request/response packets
// for the Hawk ATT lookup path. Address width comes from `HACD_AXI4_ADDR_WIDTH.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 48
`endif

package hacd_pkg;

  localparam int AW    = `HACD_AXI4_ADDR_WIDTH;
  localparam int PPN_W = AW - 12;

  localparam logic [1:0] ST_DEALLOC    = 2'b00;
  localparam logic [1:0] ST_ALLOC      = 2'b01;
  localparam logic [1:0] ST_COMPRESSED = 2'b10;
  localparam logic [1:0] ST_RSVD       = 2'b11;

  localparam int ENT_STS_LSB = 0;
  localparam int ENT_PPA_LSB = 12;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READY    = 3'd1,
    S_RD_ATT   = 3'd2,
    S_WAIT_ATT = 3'd3,
    S_ALLOC_WR = 3'd4,
    S_WAIT_WR  = 3'd5
  } lkup_st_e;

  typedef struct packed {
    logic             lookup;
    logic [PPN_W-1:0] hppa;
    logic             zeroBlkWr;
  } att_lkup_reqpkt_t;

  typedef struct packed {
    logic [PPN_W-1:0] ppa;
    logic [1:0]       sts;
    logic             allow_access;
    logic             zeroBlkWr;
  } trnsl_reqpkt_t;

  function automatic logic [63:0] att_entry(
    input logic [PPN_W-1:0] ppn,
    input logic [1:0]       sts
  );
    logic [63:0] e;
    e = '0;
    e[ENT_PPA_LSB +: PPN_W] = ppn;
    e[ENT_STS_LSB +: 2]     = sts;
    return e;
  endfunction

  function automatic logic [PPN_W-1:0] att_ppa(
    input logic [63:0] e
  );
    return e[ENT_PPA_LSB +: PPN_W];
  endfunction

  function automatic logic [1:0] att_sts(
    input logic [63:0] e
  );
    return e[ENT_STS_LSB +: 2];
  endfunction

endpackage

// File: rtl/hawk_att_lkup_resp_cache.sv
// hawk_att_lkup_cache: one-entry last-translation cache {valid, hppa, ppa}.
// Ports: i_cap/i_lkup_hppa latch the request, i_fill/i_fill_ppa install it, o_hit/o_ppa.
`ifdef HAWK_ATT_LKUP_CACHE_EN
module hawk_att_lkup_cache
  import hacd_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             i_cap,
  input  logic [PPN_W-1:0] i_lkup_hppa,
  input  logic             i_fill,
  input  logic [PPN_W-1:0] i_fill_ppa,
  output logic             o_hit,
  output logic [PPN_W-1:0] o_ppa
);

  logic             r_valid;
  logic [PPN_W-1:0] r_hppa;
  logic [PPN_W-1:0] r_ppa;
  logic [PPN_W-1:0] r_pend_hppa;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid     <= 1'b0;
      r_hppa      <= '0;
      r_ppa       <= '0;
      r_pend_hppa <= '0;
    end else begin
      if (i_cap) r_pend_hppa <= i_lkup_hppa;
      if (i_fill) begin
        r_valid <= 1'b1;
        r_hppa  <= r_pend_hppa;
        r_ppa   <= i_fill_ppa;
      end
    end
  end

  assign o_hit = r_valid && (r_hppa == i_lkup_hppa);
  assign o_ppa = r_ppa;

endmodule
`endif

// File: rtl/hawk_att_lkup_resp.sv
// hawk_att_lkup_resp: reads/decodes the ATT entry per lookup, allocates from a
// linear free-page pointer. Ports: lookup req/resp, ATT rd/wr ports, lkup_state.
// Optional HAWK_ATT_LKUP_CACHE_EN adds a one-entry last-translation cache.
module hawk_att_lkup_resp
  import hacd_pkg::*;
#(
  parameter logic [AW-1:0]    ATT_BASE      = '0,
  parameter logic [PPN_W-1:0] HPPA_BASE     = PPN_W'('h80000),
  parameter logic [PPN_W-1:0] FREE_BASE_PPN = PPN_W'('h90000),
  parameter logic [PPN_W-1:0] FREE_END_PPN  = PPN_W'('h9FFFF)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             init_list_done,
  input  att_lkup_reqpkt_t lkup_reqpkt,
  output logic             pgrd_mngr_ready,
  output trnsl_reqpkt_t    trnsl_reqpkt,
  output logic             rd_req_valid,
  input  logic             rd_req_ready,
  output logic [AW-1:0]    rd_req_addr,
  input  logic             rd_rsp_valid,
  input  logic [63:0]      rd_rsp_data,
  output logic             wr_req_valid,
  input  logic             wr_req_ready,
  output logic [AW-1:0]    wr_req_addr,
  output logic [63:0]      wr_req_data,
  input  logic             wr_done,
  output logic [2:0]       lkup_state
);

  lkup_st_e         r_state;
  logic             r_ready;
  logic             r_rd_valid;
  logic             r_wr_valid;
  logic [AW-1:0]    r_rd_addr;
  logic [AW-1:0]    r_wr_addr;
  logic [63:0]      r_wr_data;
  trnsl_reqpkt_t    r_trnsl;
  logic             r_zblk;
  // one extra bit so the pointer can sit at FREE_END_PPN+1 when exhausted
  logic [PPN_W:0]   r_free_ppn;

  logic [PPN_W-1:0] w_idx;
  logic [AW-1:0]    w_rd_addr;
  logic [1:0]       w_ent_sts;
  logic [PPN_W-1:0] w_ent_ppa;
  logic             w_pool_empty;
  logic             w_hit;
  logic [PPN_W-1:0] w_hit_ppa;

  assign w_idx        = lkup_reqpkt.hppa - HPPA_BASE;
  assign w_rd_addr    = ATT_BASE + AW'({w_idx, 3'b000});
  assign w_ent_sts    = att_sts(rd_rsp_data);
  assign w_ent_ppa    = att_ppa(rd_rsp_data);
  assign w_pool_empty = r_free_ppn > {1'b0, FREE_END_PPN};

`ifdef HAWK_ATT_LKUP_CACHE_EN
  logic             w_cap;
  logic             w_fill;
  logic [PPN_W-1:0] w_fill_ppa;

  assign w_cap  = (r_state == S_READY) && lkup_reqpkt.lookup;
  assign w_fill =
    ((r_state == S_WAIT_ATT) && rd_rsp_valid &&
     (w_ent_sts == ST_ALLOC)) ||
    ((r_state == S_WAIT_WR) && wr_done);
  assign w_fill_ppa = (r_state == S_WAIT_WR) ?
                      r_free_ppn[PPN_W-1:0] : w_ent_ppa;

  hawk_att_lkup_cache u_cache (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_cap       (w_cap),
    .i_lkup_hppa (lkup_reqpkt.hppa),
    .i_fill      (w_fill),
    .i_fill_ppa  (w_fill_ppa),
    .o_hit       (w_hit),
    .o_ppa       (w_hit_ppa)
  );
`else
  assign w_hit     = 1'b0;
  assign w_hit_ppa = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_trnsl    <= '0;
      r_zblk     <= 1'b0;
      r_free_ppn <= {1'b0, FREE_BASE_PPN};
    end else begin
      r_trnsl.allow_access <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (init_list_done) begin
            r_ready <= 1'b1;
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (lkup_reqpkt.lookup) begin
            r_zblk <= lkup_reqpkt.zeroBlkWr;
            if (w_hit) begin
              // cached hit: answer now, stay ready
              r_trnsl.ppa          <= w_hit_ppa;
              r_trnsl.sts          <= ST_ALLOC;
              r_trnsl.allow_access <= 1'b1;
              r_trnsl.zeroBlkWr    <= lkup_reqpkt.zeroBlkWr;
            end else begin
              r_ready    <= 1'b0;
              r_rd_valid <= 1'b1;
              r_rd_addr  <= w_rd_addr;
              r_state    <= S_RD_ATT;
            end
          end
        end
        S_RD_ATT: begin
          if (rd_req_ready) begin
            r_rd_valid <= 1'b0;
            r_state    <= S_WAIT_ATT;
          end
        end
        S_WAIT_ATT: begin
          if (rd_rsp_valid) begin
            unique case (1'b1)
              (w_ent_sts == ST_ALLOC): begin
                r_trnsl.ppa          <= w_ent_ppa;
                r_trnsl.sts          <= ST_ALLOC;
                r_trnsl.allow_access <= 1'b1;
                r_trnsl.zeroBlkWr    <= r_zblk;
                r_ready              <= 1'b1;
                r_state              <= S_READY;
              end
              (w_ent_sts == ST_COMPRESSED): begin
                r_trnsl.sts       <= ST_COMPRESSED;
                r_trnsl.zeroBlkWr <= r_zblk;
                r_ready           <= 1'b1;
                r_state           <= S_READY;
              end
              (w_ent_sts == ST_DEALLOC) && !w_pool_empty: begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= r_rd_addr;
                r_wr_data  <= att_entry(r_free_ppn[PPN_W-1:0],
                                        ST_ALLOC);
                r_state    <= S_ALLOC_WR;
              end
              default: begin
                // exhausted pool or reserved entry
                r_trnsl.sts       <= ST_RSVD;
                r_trnsl.zeroBlkWr <= r_zblk;
                r_ready           <= 1'b1;
                r_state           <= S_READY;
              end
            endcase
          end
        end
        S_ALLOC_WR: begin
          if (wr_req_ready) begin
            r_wr_valid <= 1'b0;
            r_state    <= S_WAIT_WR;
          end
        end
        S_WAIT_WR: begin
          if (wr_done) begin
            r_trnsl.ppa          <= r_free_ppn[PPN_W-1:0];
            r_trnsl.sts          <= ST_ALLOC;
            r_trnsl.allow_access <= 1'b1;
            r_trnsl.zeroBlkWr    <= r_zblk;
            r_free_ppn           <= r_free_ppn + 1'b1;
            r_ready              <= 1'b1;
            r_state              <= S_READY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pgrd_mngr_ready = r_ready;
  assign trnsl_reqpkt    = r_trnsl;
  assign rd_req_valid    = r_rd_valid;
  assign rd_req_addr     = r_rd_addr;
  assign wr_req_valid    = r_wr_valid;
  assign wr_req_addr     = r_wr_addr;
  assign wr_req_data     = r_wr_data;
  assign lkup_state      = r_state;

endmodule

// File: tb/tb_hawk_att_lkup_resp.sv
// tb_hawk_att_lkup_resp: random lookups against a memory model and a
// behavioural translation model; directed zero-wait latency cases first.
module tb_hawk_att_lkup_resp;
  import hacd_pkg::*;

  localparam logic [AW-1:0]    ATT_B = AW'('h1000);
  localparam logic [PPN_W-1:0] HP_B  = PPN_W'('h80000);
  localparam logic [PPN_W-1:0] FR_B  = PPN_W'('h90000);
  localparam logic [PPN_W-1:0] FR_E  = PPN_W'('h90003);

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b1;
  logic             init_list_done = 1'b0;
  att_lkup_reqpkt_t lkup_reqpkt = '0;
  logic             pgrd_mngr_ready;
  trnsl_reqpkt_t    trnsl_reqpkt;
  logic             rd_req_valid;
  logic             rd_req_ready = 1'b0;
  logic [AW-1:0]    rd_req_addr;
  logic             rd_rsp_valid = 1'b0;
  logic [63:0]      rd_rsp_data = '0;
  logic             wr_req_valid;
  logic             wr_req_ready = 1'b0;
  logic [AW-1:0]    wr_req_addr;
  logic [63:0]      wr_req_data;
  logic             wr_done = 1'b0;
  logic [2:0]       lkup_state;

  hawk_att_lkup_resp #(
    .ATT_BASE      (ATT_B),
    .HPPA_BASE     (HP_B),
    .FREE_BASE_PPN (FR_B),
    .FREE_END_PPN  (FR_E)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .init_list_done  (init_list_done),
    .lkup_reqpkt     (lkup_reqpkt),
    .pgrd_mngr_ready (pgrd_mngr_ready),
    .trnsl_reqpkt    (trnsl_reqpkt),
    .rd_req_valid    (rd_req_valid),
    .rd_req_ready    (rd_req_ready),
    .rd_req_addr     (rd_req_addr),
    .rd_rsp_valid    (rd_rsp_valid),
    .rd_rsp_data     (rd_rsp_data),
    .wr_req_valid    (wr_req_valid),
    .wr_req_ready    (wr_req_ready),
    .wr_req_addr     (wr_req_addr),
    .wr_req_data     (wr_req_data),
    .wr_done         (wr_done),
    .lkup_state      (lkup_state)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory environment
  logic [63:0]   mem [logic [AW-1:0]];
  bit            zw = 1'b1;
  bit            rd_pend = 1'b0;
  bit            wr_pend = 1'b0;
  int            rd_dly, wr_dly;
  logic [63:0]   rd_q;
  int            rd_hs = 0;
  int            wr_hs = 0;
  int            aa_cnt = 0;
  logic [AW-1:0] hs_rd_addr = '0;
  logic [AW-1:0] hs_wr_addr = '0;
  logic [63:0]   hs_wr_data = '0;

  // reference model
  longint           m_free;
  bit               m_cv;
  logic [PPN_W-1:0] m_ch, m_cp, m_ppa;
  logic [1:0]       m_sts;

  function automatic logic [63:0] mem_rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  function automatic logic [AW-1:0] ent_addr(input logic [PPN_W-1:0] h);
    return ATT_B + (AW'(h) - AW'(HP_B)) * 8;
  endfunction

  task automatic model_reset();
    m_free = longint'(FR_B);
    m_cv   = 1'b0;
    m_ch   = '0;
    m_cp   = '0;
    m_ppa  = '0;
    m_sts  = 2'b00;
  endtask

  task automatic tick();
    @(negedge clk_i);
    rd_rsp_valid = 1'b0;
    wr_done      = 1'b0;
    rd_rsp_data  = {$urandom, $urandom};
    if (rd_pend) begin
      if (rd_dly == 0) begin
        rd_rsp_valid = 1'b1;
        rd_rsp_data  = rd_q;
        rd_pend      = 1'b0;
      end else rd_dly--;
    end
    if (wr_pend) begin
      if (wr_dly == 0) begin
        wr_done = 1'b1;
        wr_pend = 1'b0;
      end else wr_dly--;
    end
    if (trnsl_reqpkt.allow_access) aa_cnt++;
    rd_req_ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
    wr_req_ready = zw ? 1'b1 : 1'($urandom_range(0, 1));
    if (rd_req_valid && rd_req_ready) begin
      rd_hs++;
      hs_rd_addr = rd_req_addr;
      rd_q       = mem_rd(rd_req_addr);
      rd_pend    = 1'b1;
      rd_dly     = zw ? 0 : int'($urandom_range(0, 2));
    end
    if (wr_req_valid && wr_req_ready) begin
      wr_hs++;
      hs_wr_addr        = wr_req_addr;
      hs_wr_data        = wr_req_data;
      mem[wr_req_addr]  = wr_req_data;
      wr_pend           = 1'b1;
      wr_dly            = zw ? 0 : int'($urandom_range(0, 2));
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!pgrd_mngr_ready && k < 100) begin
      tick();
      k++;
    end
    chk("ready_before_lookup", 64'(pgrd_mngr_ready), 64'd1);
  endtask

  task automatic lookup(input logic [PPN_W-1:0] h, input logic zb);
    logic [AW-1:0]    a;
    logic [63:0]      e, xwd;
    bit               hit, xrd, xwr, xaa;
    logic [PPN_W-1:0] xppa;
    logic [1:0]       xsts;
    int               xlat, lat, rd0, wr0, aa0;
    wait_ready();
    a    = ent_addr(h);
    e    = mem_rd(a);
    hit  = 1'b0;
    xrd  = 1'b1;
    xwr  = 1'b0;
    xaa  = 1'b0;
    xppa = m_ppa;
    xsts = 2'b11;
    xlat = 3;
    xwd  = '0;
`ifdef HAWK_ATT_LKUP_CACHE_EN
    if (m_cv && m_ch == h) begin
      hit  = 1'b1;
      xrd  = 1'b0;
      xppa = m_cp;
      xsts = 2'b01;
      xaa  = 1'b1;
      xlat = 1;
    end
`endif
    if (!hit) begin
      if (e % 4 == 1) begin
        xppa = PPN_W'(e >> 12);
        xsts = 2'b01;
        xaa  = 1'b1;
        m_cv = 1'b1; m_ch = h; m_cp = xppa;
      end else if (e % 4 == 2) begin
        xsts = 2'b10;
      end else if (e % 4 == 0 && m_free <= longint'(FR_E)) begin
        xwr  = 1'b1;
        xwd  = (64'(m_free) << 12) + 64'd1;
        xppa = PPN_W'(m_free);
        xsts = 2'b01;
        xaa  = 1'b1;
        xlat = 5;
        m_free++;
        m_cv = 1'b1; m_ch = h; m_cp = xppa;
      end
    end
    m_ppa = xppa;
    m_sts = xsts;

    rd0 = rd_hs; wr0 = wr_hs; aa0 = aa_cnt;
    lkup_reqpkt = '{lookup: 1'b1, hppa: h, zeroBlkWr: zb};
    tick();
    lkup_reqpkt.lookup = 1'b0;
    lat = 1;
    if (!hit) chk("ready_drop", 64'(pgrd_mngr_ready), 64'd0);
    while (!pgrd_mngr_ready && lat < 100) begin
      tick();
      lat++;
    end
    chk("resp_ready", 64'(pgrd_mngr_ready), 64'd1);
    chk("resp_allow", 64'(trnsl_reqpkt.allow_access), 64'(xaa));
    chk("resp_ppa", 64'(trnsl_reqpkt.ppa), 64'(xppa));
    chk("resp_sts", 64'(trnsl_reqpkt.sts), 64'(xsts));
    chk("resp_zblk", 64'(trnsl_reqpkt.zeroBlkWr), 64'(zb));
    if (zw) chk("latency", 64'(lat), 64'(xlat));
    chk("rd_count", 64'(rd_hs - rd0), 64'(xrd));
    if (xrd) chk("rd_addr", 64'(hs_rd_addr), 64'(a));
    chk("wr_count", 64'(wr_hs - wr0), 64'(xwr));
    if (xwr) begin
      chk("wr_addr", 64'(hs_wr_addr), 64'(a));
      chk("wr_data", hs_wr_data, xwd);
    end
    tick();
    chk("allow_pulse", 64'(aa_cnt - aa0), 64'(xaa));
    chk("allow_low", 64'(trnsl_reqpkt.allow_access), 64'd0);
  endtask

  task automatic mid_reset(input logic [PPN_W-1:0] h);
    wait_ready();
    lkup_reqpkt = '{lookup: 1'b1, hppa: h, zeroBlkWr: 1'b1};
    tick();
    lkup_reqpkt.lookup = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    chk("rst_ready", 64'(pgrd_mngr_ready), 64'd0);
    chk("rst_trnsl", 64'(trnsl_reqpkt), 64'd0);
    chk("rst_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_wr_valid", 64'(wr_req_valid), 64'd0);
    chk("rst_rd_addr", 64'(rd_req_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_req_addr), 64'd0);
    chk("rst_wr_data", wr_req_data, 64'd0);
    rd_pend = 1'b0;
    wr_pend = 1'b0;
    rd_rsp_valid = 1'b0;
    wr_done = 1'b0;
    model_reset();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [63:0] e;
    logic [AW-1:0] a;
    model_reset();
    #1 rst_ni = 1'b0;
    tick();
    tick();
    chk("reset_ready", 64'(pgrd_mngr_ready), 64'd0);
    chk("reset_trnsl", 64'(trnsl_reqpkt), 64'd0);
    chk("reset_rd_valid", 64'(rd_req_valid), 64'd0);
    chk("reset_wr_valid", 64'(wr_req_valid), 64'd0);
    chk("reset_rd_addr", 64'(rd_req_addr), 64'd0);
    chk("reset_wr_data", wr_req_data, 64'd0);
    rst_ni = 1'b1;

    // lookups before init_list_done are ignored
    lkup_reqpkt = '{lookup: 1'b1, hppa: PPN_W'('h80005), zeroBlkWr: 1'b0};
    tick();
    lkup_reqpkt.lookup = 1'b0;
    repeat (5) tick();
    chk("noinit_ready", 64'(pgrd_mngr_ready), 64'd0);
    chk("noinit_rd", 64'(rd_hs), 64'd0);
    init_list_done = 1'b1;

    mem[ent_addr(PPN_W'('h80005))] = 64'h0000_0000_9123_4001;
    mem[ent_addr(PPN_W'('h80003))] = 64'h0000_0000_A555_5002;
    mem[ent_addr(PPN_W'('h80004))] = 64'h0000_0000_1234_5003;

    lookup(PPN_W'('h80005), 1'b0);
    chk("dir_addr_80005", 64'(hs_rd_addr), 64'(ATT_B) + 64'h28);
    chk("dir_ppa_80005", 64'(trnsl_reqpkt.ppa), 64'h91234);
    lookup(PPN_W'('h80001), 1'b1);
    chk("dir_wr_addr", 64'(hs_wr_addr), 64'(ATT_B) + 64'h8);
    chk("dir_wr_data", hs_wr_data, 64'h9000_0001);
    lookup(PPN_W'('h80002), 1'b0);
    chk("dir_ppa_2nd", 64'(trnsl_reqpkt.ppa), 64'h90001);
    lookup(PPN_W'('h80003), 1'b0);
    chk("dir_comp_sts", 64'(trnsl_reqpkt.sts), 64'h2);
    lookup(PPN_W'('h80004), 1'b1);
    lookup(PPN_W'('h80006), 1'b0);
    lookup(PPN_W'('h80007), 1'b1);
    chk("dir_last_ppn", 64'(trnsl_reqpkt.ppa), 64'h90003);
    lookup(PPN_W'('h80008), 1'b0);
    chk("dir_exh_sts", 64'(trnsl_reqpkt.sts), 64'h3);
    lookup(PPN_W'('h80007), 1'b0);
    lookup(PPN_W'('h80005), 1'b1);
    lookup(PPN_W'('h80005), 1'b0);
    mid_reset(PPN_W'('h80003));
    lookup(PPN_W'('h80005), 1'b0);
    lookup(PPN_W'('h80009), 1'b0);

    // random phase with backpressure and variable latency
    zw = 1'b0;
    for (int i = 10; i < 32; i++) begin
      a = ent_addr(HP_B + PPN_W'(i));
      if (!mem.exists(a)) begin
        e = {$urandom, $urandom};
        e[1:0] = 2'($urandom_range(0, 3));
        mem[a] = e;
      end
    end
    for (int i = 0; i < 300; i++) begin
      if (i % 75 == 74)
        mid_reset(HP_B + PPN_W'($urandom_range(0, 31)));
      else
        lookup(HP_B + PPN_W'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
